adc_spi_sampler: RTL and testbench
==================================

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 Parameter SAMP_DIV, 1000, clk cycles between conversion ticks (50 kHz at 50 MHz clk).
REQ-002 Parameter SCLK_DIV, 4, clk cycles per adc_sclk half-period; legal range 1 and above.
REQ-003 Parameter CS_SETUP, 2, clk cycles from adc_cs_n fall to first adc_sclk rise; legal range 1 and above.
REQ-004 Parameter constraint: SAMP_DIV > CS_SETUP + 32*SCLK_DIV + 2.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  conversion enable.
REQ-008 adc_sdo  input  1  ADC serial data; MSB first; changes after adc_sclk falling edge.
REQ-009 adc_cs_n  output  1  ADC chip select, active-low.
REQ-010 adc_sclk  output  1  ADC serial clock; idles low.
REQ-011 sample  output  16  last completed raw ADC code, unsigned, held between updates.
REQ-012 samp_valid  output  1  one-clk pulse when sample updates; feeds the downstream filter's sample strobe.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 overrun  output  1  sticky flag: a tick arrived while a transfer was in progress.

Function
REQ-015 Period counter: counts 0..SAMP_DIV-1 while en=1 and wraps; tick asserts for one cycle at count SAMP_DIV-1.
REQ-016 Period counter: held at 0 while en=0.
REQ-017 FSM states: IDLE, SETUP, SHIFT, DONE; all outputs registered.
REQ-018 IDLE -> SETUP on tick; adc_cs_n goes low in the cycle after the tick (T+1).
REQ-019 SETUP lasts exactly CS_SETUP cycles (T+1..T+CS_SETUP); adc_sclk stays low.
REQ-020 SHIFT: 16 adc_sclk periods, each SCLK_DIV cycles high followed by SCLK_DIV cycles low; first rise at T+CS_SETUP+1.
REQ-021 adc_sdo is sampled in the last clk cycle of each adc_sclk high half-period.
REQ-022 Sampled bits shift MSB first into a 16-bit shift register.
REQ-023 4-bit bit counter runs 0..15; SHIFT ends after the low half following bit 15.
REQ-024 DONE occupies a single cycle at T+CS_SETUP+32*SCLK_DIV+1 (131 with defaults).
REQ-025 In DONE: adc_cs_n=1, sample loads from the shift register, samp_valid=1; next state IDLE.
REQ-026 samp_valid is exactly one cycle wide; sample is unchanged at all other times.
REQ-027 A tick in any state other than IDLE is ignored and sets overrun.
REQ-028 overrun clears only on nrst low or en=0.
REQ-029 en falling mid-transfer: the current transfer completes normally including samp_valid, then the FSM stays IDLE.
REQ-030 en rising: first tick occurs SAMP_DIV cycles later.
REQ-031 Tick coinciding with DONE counts as overrun and does not start a transfer.
REQ-032 adc_cs_n is high in IDLE and DONE.
REQ-033 adc_sclk is low outside SHIFT.

Reset
REQ-034 nrst low asynchronously forces:
- FSM to IDLE
- period counter, bit counter, shift register and sample to 0
- samp_valid, busy, overrun and adc_sclk to 0
- adc_cs_n to 1
REQ-035 Reset mid-transfer aborts it with no samp_valid; after release, the next conversion starts on the first tick.

Verification
REQ-036 Defaults, en=1, ADC model returns 0xA5C3 -> adc_cs_n falls at T+1, first adc_sclk rise at T+3, samp_valid at T+131, sample=0xA5C3.
REQ-037 Successive codes 0x0000, 0xFFFF, 0x8001 -> samp_valid pulses exactly 1000 cycles apart with matching sample values; overrun stays 0.
REQ-038 SAMP_DIV=100, SCLK_DIV=4 -> ticks land mid-transfer, overrun=1 and stays 1; en pulsed low -> overrun=0.
REQ-039 en dropped at bit 7 of a transfer returning 0x1234 -> transfer completes with sample=0x1234, then no further adc_cs_n activity.
REQ-040 nrst asserted at bit 10 -> adc_cs_n=1, adc_sclk=0, sample=0 immediately, no samp_valid; after release, next conversion starts on its tick.
REQ-041 SCLK_DIV=1, CS_SETUP=1 -> adc_sclk period 2 clk, samp_valid at T+34, sample bit-exact.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// ---------------------------------------------------------------------------
// adc_spi_sampler
//   Periodic SPI ADC reader: a period counter raises a conversion tick, a
//   four-state FSM frames the transfer with adc_cs_n, generates adc_sclk,
//   shifts in 16 bits MSB first and publishes the code with a one-cycle
//   samp_valid strobe. Ticks arriving mid-transfer set a sticky overrun flag.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module adc_spi_sampler #(
   parameter int SAMP_DIV = 1000,
   parameter int SCLK_DIV = 4,
   parameter int CS_SETUP = 2
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en,
   input  logic        adc_sdo,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic [15:0] sample,
   output logic        samp_valid,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int PW   = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
   localparam int CMAX = (CS_SETUP > SCLK_DIV) ? CS_SETUP : SCLK_DIV;
   localparam int CW   = $clog2(CMAX + 1);

   logic [PW-1:0] per_cnt;
   logic          tick;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;          // SETUP length / sclk half-period timer
   logic [3:0]    bit_cnt, bit_nx;
   logic [15:0]   shreg, shreg_nx;
   logic [15:0]   sample_nx;
   logic          cs_nx, sclk_nx, valid_nx, busy_nx, overrun_nx;

   // Tick on the last count of each period; never while disabled.
   assign tick = en && (per_cnt == PW'(SAMP_DIV - 1));

   // Free-running period counter, parked at zero while conversion is disabled.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         per_cnt <= '0;
      else if (!en || tick)
         per_cnt <= '0;
      else
         per_cnt <= per_cnt + 1'b1;
   end

   // State and every output register; outputs move together with the state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         sample     <= '0;
         adc_cs_n   <= 1'b1;
         adc_sclk   <= 1'b0;
         samp_valid <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         bit_cnt    <= bit_nx;
         shreg      <= shreg_nx;
         sample     <= sample_nx;
         adc_cs_n   <= cs_nx;
         adc_sclk   <= sclk_nx;
         samp_valid <= valid_nx;
         busy       <= busy_nx;
         overrun    <= overrun_nx;
      end
   end

   // Next-state and next-output decode for the transfer sequencer.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_nx     = bit_cnt;
      shreg_nx   = shreg;
      sample_nx  = sample;
      cs_nx      = adc_cs_n;
      sclk_nx    = adc_sclk;
      valid_nx   = 1'b0;
      overrun_nx = overrun;

      case (state)
         IDLE: begin
            if (tick) begin
               state_nx = SETUP;
               cnt_nx   = '0;
               cs_nx    = 1'b0;
            end
         end
         SETUP: begin
            if (cnt == CW'(CS_SETUP - 1)) begin
               state_nx = SHIFT;
               cnt_nx   = '0;
               bit_nx   = '0;
               sclk_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt == CW'(SCLK_DIV - 1)) begin
               cnt_nx = '0;
               if (adc_sclk) begin
                  // Last cycle of the high half: data has been stable since the
                  // previous falling edge, so capture it here.
                  shreg_nx = {shreg[14:0], adc_sdo};
                  sclk_nx  = 1'b0;
               end else if (bit_cnt == 4'd15) begin
                  state_nx  = DONE;
                  cs_nx     = 1'b1;
                  sample_nx = shreg;
                  valid_nx  = 1'b1;
               end else begin
                  bit_nx  = bit_cnt + 4'd1;
                  sclk_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cs_nx    = 1'b1;
            sclk_nx  = 1'b0;
         end
      endcase

      busy_nx = (state_nx != IDLE);

      // Disabling clears the sticky flag; a tick outside IDLE (DONE included) sets it.
      if (!en)
         overrun_nx = 1'b0;
      else if (tick && (state != IDLE))
         overrun_nx = 1'b1;
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_sampler
//   Three sampler instances (default timing, short period for overrun,
//   fastest sclk) each driven by a behavioural SPI ADC. Expected codes and
//   timings come from the transfer rules, not from the RTL structure.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_spi_sampler;

   logic        clk;
   logic        nrst;
   logic [2:0]  en;
   logic [2:0]  cs_n, sclk, sdo, sv, busy, ovr;
   logic [15:0] sample   [3];
   logic [15:0] adc_code [3];
   int          cyc;
   int          n_checks;
   int          n_fail;

   adc_spi_sampler #(.SAMP_DIV(1000), .SCLK_DIV(4), .CS_SETUP(2)) dut0 (
      .clk(clk), .nrst(nrst), .en(en[0]), .adc_sdo(sdo[0]),
      .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample(sample[0]),
      .samp_valid(sv[0]), .busy(busy[0]), .overrun(ovr[0]));

   adc_spi_sampler #(.SAMP_DIV(100), .SCLK_DIV(4), .CS_SETUP(2)) dut1 (
      .clk(clk), .nrst(nrst), .en(en[1]), .adc_sdo(sdo[1]),
      .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample(sample[1]),
      .samp_valid(sv[1]), .busy(busy[1]), .overrun(ovr[1]));

   adc_spi_sampler #(.SAMP_DIV(50), .SCLK_DIV(1), .CS_SETUP(1)) dut2 (
      .clk(clk), .nrst(nrst), .en(en[2]), .adc_sdo(sdo[2]),
      .adc_cs_n(cs_n[2]), .adc_sclk(sclk[2]), .sample(sample[2]),
      .samp_valid(sv[2]), .busy(busy[2]), .overrun(ovr[2]));

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ADC: presents code MSB first, advancing one bit after each sclk fall.
   for (genvar g = 0; g < 3; g++) begin : g_adc
      logic [4:0] idx;
      logic       prev_sclk;
      initial begin
         idx       = '0;
         prev_sclk = 1'b0;
      end
      always @(negedge clk) begin
         if (cs_n[g])
            idx <= '0;
         else if (prev_sclk && !sclk[g])
            idx <= idx + 5'd1;
         prev_sclk <= sclk[g];
      end
      assign sdo[g] = (!cs_n[g] && !idx[4]) ? adc_code[g][~idx[3:0]] : 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cs_fall(input int d, input int limit, output bit ok);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!cs_n[d]) break;
      end
      check("cs_fall", {31'd0, cs_n[d]}, 32'd0);
      ok = !cs_n[d];
   endtask

   // One complete conversion: expected code, framing, sclk count and latency.
   task automatic run_xfer(input int d, input logic [15:0] code, input int setup,
                           input int sdiv, input int exp_lead, input int ref_time,
                           input int drop_bit, output int sv_time);
      bit ok, got, prev;
      int t0, first, rises;
      sv_time = -1;
      adc_code[d] = code;
      wait_cs_fall(d, 3000, ok);
      if (!ok) return;
      t0 = cyc;
      if (exp_lead >= 0) check("cs_lead", t0 - ref_time, exp_lead);
      prev = 1'b0; got = 1'b0; first = -1; rises = 0;
      for (int i = 0; i < 4000 && !got; i++) begin
         @(negedge clk);
         if (sclk[d] && !prev) begin
            rises++;
            if (rises == 1) first = cyc;
            if (rises == drop_bit + 1) en[d] = 1'b0;
         end
         prev = sclk[d];
         if (sv[d]) got = 1'b1;
      end
      check("samp_valid_seen", {31'd0, got}, 32'd1);
      if (!got) return;
      sv_time = cyc;
      check("sclk_first_rise", first - t0, setup);
      check("done_latency", sv_time - t0, setup + 32 * sdiv);
      check("sclk_rises", rises, 16);
      check("sample", {16'd0, sample[d]}, {16'd0, code});
      check("cs_n_in_done", {31'd0, cs_n[d]}, 32'd1);
      check("sclk_in_done", {31'd0, sclk[d]}, 32'd0);
      check("busy_in_done", {31'd0, busy[d]}, 32'd1);
      @(negedge clk);
      check("samp_valid_width", {31'd0, sv[d]}, 32'd0);
      check("busy_idle", {31'd0, busy[d]}, 32'd0);
      check("sample_hold", {16'd0, sample[d]}, {16'd0, code});
   endtask

   // Watchdog so the run always ends.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main stimulus sequence.
   initial begin
      logic [15:0] fixed [3];
      logic [15:0] code;
      int          c0, t_prev, t, cs_act, rises;
      bit          ok, prev, sv_seen;

      n_checks = 0;
      n_fail   = 0;
      nrst     = 1'b0;
      en       = '0;
      for (int i = 0; i < 3; i++) adc_code[i] = '0;
      fixed[0] = 16'h0000; fixed[1] = 16'hFFFF; fixed[2] = 16'h8001;

      repeat (3) @(negedge clk);
      check("rst_cs_n",    {31'd0, cs_n[0]}, 32'd1);
      check("rst_sclk",    {31'd0, sclk[0]}, 32'd0);
      check("rst_sample",  {16'd0, sample[0]}, 32'd0);
      check("rst_valid",   {31'd0, sv[0]}, 32'd0);
      check("rst_busy",    {31'd0, busy[0]}, 32'd0);
      check("rst_overrun", {31'd0, ovr[0]}, 32'd0);

      nrst = 1'b1;
      @(negedge clk);
      en[0] = 1'b1;
      c0 = cyc;
      run_xfer(0, 16'hA5C3, 2, 4, 1000, c0, -1, t_prev);

      // Back-to-back conversions: strobes exactly one period apart.
      for (int i = 0; i < 6; i++) begin
         code = (i < 3) ? fixed[i] : 16'($urandom);
         run_xfer(0, code, 2, 4, -1, 0, -1, t);
         check("sv_spacing", t - t_prev, 1000);
         t_prev = t;
      end
      check("no_overrun", {31'd0, ovr[0]}, 32'd0);

      // Enable dropped during bit 7: transfer completes, then silence.
      run_xfer(0, 16'h1234, 2, 4, -1, 0, 7, t);
      cs_act = 0;
      repeat (2500) begin
         @(negedge clk);
         if (!cs_n[0]) cs_act++;
      end
      check("cs_quiet_after_en_drop", cs_act, 0);
      check("sample_after_en_drop", {16'd0, sample[0]}, 32'h1234);

      // Reset asserted during bit 10 aborts the transfer.
      en[0] = 1'b1;
      adc_code[0] = 16'($urandom);
      wait_cs_fall(0, 3000, ok);
      prev = 1'b0; rises = 0;
      for (int i = 0; i < 2000 && rises < 11; i++) begin
         @(negedge clk);
         if (sclk[0] && !prev) rises++;
         prev = sclk[0];
      end
      check("bit10_reached", rises, 11);
      nrst = 1'b0;
      #1;
      check("arst_cs_n",   {31'd0, cs_n[0]}, 32'd1);
      check("arst_sclk",   {31'd0, sclk[0]}, 32'd0);
      check("arst_sample", {16'd0, sample[0]}, 32'd0);
      check("arst_busy",   {31'd0, busy[0]}, 32'd0);
      sv_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         sv_seen = sv_seen | sv[0];
      end
      check("arst_no_valid", {31'd0, sv_seen}, 32'd0);
      nrst = 1'b1;
      c0 = cyc;
      run_xfer(0, 16'($urandom), 2, 4, 1000, c0, -1, t);
      en[0] = 1'b0;

      // Short period: ticks land mid-transfer and overrun latches.
      en[1] = 1'b1;
      repeat (50) @(negedge clk);
      check("ovr_before_tick", {31'd0, ovr[1]}, 32'd0);
      repeat (350) @(negedge clk);
      check("ovr_set", {31'd0, ovr[1]}, 32'd1);
      repeat (300) @(negedge clk);
      check("ovr_sticky", {31'd0, ovr[1]}, 32'd1);
      en[1] = 1'b0;
      @(negedge clk);
      check("ovr_cleared", {31'd0, ovr[1]}, 32'd0);

      // Fastest sclk and minimum setup.
      en[2] = 1'b1;
      c0 = cyc;
      run_xfer(2, 16'($urandom), 1, 1, 50, c0, -1, t_prev);
      for (int i = 0; i < 4; i++) begin
         run_xfer(2, 16'($urandom), 1, 1, -1, 0, -1, t);
         check("fast_sv_spacing", t - t_prev, 50);
         t_prev = t;
      end
      check("fast_no_overrun", {31'd0, ovr[2]}, 32'd0);
      en[2] = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
